chan_mux_reg: RTL
=================

# chan_mux_reg

Parametrised, registered N-channel, W-bit selector: the clocked successor to the gate-level 4:1 mux. It picks one input channel per cycle, either by an explicit select (fixed mode) or by a round-robin scan of requesting channels. The chosen word is delivered through a single output register with a valid/ready handshake. It sits between several producers and one consumer wherever the design previously used a combinational mux.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), select/channel-index width (derived; do not override)

- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used in fixed mode
- out_data  output  WIDTH  registered selected word
- out_ch  output  SEL_W  index of channel that produced out_data
- out_valid  output  1  out_data/out_ch hold a word
- out_ready  input  1  consumer accept
- sel_err  output  1  registered; high for one cycle after a fixed-mode cycle with sel ≥ CHANNELS

## Operation
- Internal state:
  - output register (out_data, out_ch, out_valid);
  - round-robin pointer ptr (SEL_W bits, range 0..CHANNELS-1);
  - sel_err flop.
- Load enable: load_en = !out_valid || out_ready.
- Fixed mode (mode=0):
  - Candidate is sel.
  - in_ready[c] = load_en && c==sel && sel<CHANNELS.
  - Capture when in_ready[sel] && in_valid[sel].
- Round-robin mode (mode=1):
  - Winner is the first c with in_valid[c]=1, scanning ptr, ptr+1, …, wrapping CHANNELS-1→0.
  - in_ready[winner] = load_en; all other in_ready bits are 0.
- Capture:
  - out_data ← in_data[winner], out_ch ← winner, out_valid ← 1.
  - In mode 1, ptr ← (winner+1) mod CHANNELS. Wrap from CHANNELS-1 goes to 0, also for non-power-of-2 CHANNELS.
- No capture while load_en=1:
  - If out_ready && out_valid, then out_valid ← 0.
  - ptr is unchanged.
- Hold: out_valid && !out_ready means all in_ready=0 and the output register and ptr stay frozen.
- Simultaneous drain and fill: with out_valid && out_ready and a valid candidate, the register is overwritten the same edge, out_valid stays 1, and there is no bubble.
- ptr advances only on a round-robin capture. Fixed-mode captures leave ptr untouched.
- Mode may change on any cycle. The new mode applies to that cycle's combinational select, and ptr is retained across mode changes.
- sel ≥ CHANNELS in mode 0:
  - No capture; in_ready all 0.
  - sel_err ← 1 on the next edge, cleared on the following edge unless the condition persists.
  - The output register still drains normally.

## Timing
- Reset: when rst_n=0 at a rising edge, the following values are loaded regardless of other inputs:
  - out_valid=0, out_data=0, out_ch=0, ptr=0, sel_err=0.
- in_ready is combinational from out_valid, out_ready, mode, sel, in_valid and ptr. It is 0 while rst_n=0.
- Latency: a word accepted at edge k (in_valid && in_ready sampled high) appears on out_data with out_valid=1 after edge k.
- Throughput: one word per cycle when out_ready is held high.
- out_data and out_ch change only on a capture edge or on reset. They are stable while out_valid && !out_ready.
- Reset asserted mid-transfer drops any held word. There is no partial state after release.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000. Release, then mode=0, sel=2, in_data ch2=0xA5 → out_data=0xA5, out_ch=2, out_valid=1 one edge later.
- Fixed-mode backpressure: mode=0, sel=1, ch1 streams 0x11, 0x12, 0x13, with out_ready=0 for 3 cycles after the first capture →
  - out_data held at 0x11 and in_ready[1]=0 during the stall;
  - after out_ready=1, the sequence 0x12, 0x13 follows back-to-back with no bubble.
- Round-robin fairness: mode=1, CHANNELS=4, all in_valid=1 continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1.
  - Then only ch2 and ch0 valid → 2,0,2,0.
- Wrap and skip: mode=1, ptr=3 (after a ch2 capture), only ch1 valid → winner ch1, ptr becomes 2. With CHANNELS=3, a ch2 capture → ptr=0.
- Mode switch and bad select:
  - mode=1 capture ch1 (ptr=2), then mode=0, sel=3 for 2 words → ptr stays 2.
  - mode=1 again with all valid → next winner ch2.
  - With CHANNELS=3, mode=0, sel=3 → no capture, in_ready=000, sel_err=1 for exactly one cycle.
- Reset mid-operation: stall with out_valid=1, out_data=0x5A, then rst_n=0 for 1 cycle → out_valid=0, ptr=0. The next round-robin capture with all valid gives out_ch=0.

Source files
------------

// File: rtl/chan_mux_reg.sv
// chan_mux_reg: registered N-channel selector, fixed or round-robin pick, valid/ready output
module chan_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);
  localparam int NP = 2 ** SEL_W;
  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(CHANNELS);
  logic [NP-1:0] v_pad;
  logic [NP*WIDTH-1:0] d_pad;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d, ptr_q, ptr_d, rr_win, cand;
  logic valid_q, valid_d, err_q, err_d;
  logic [SEL_W:0] idx;
  logic rr_hit, sel_ok, cand_ok, load_en, cap;
  // Pad to a power of two so any select value indexes safely
  assign v_pad = NP'(in_valid);
  assign d_pad = (NP * WIDTH)'(in_data);
  // Scan from the far end so the last hit is the one nearest ptr
  always_comb begin
    rr_hit = 1'b0;
    rr_win = '0;
    idx    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (SEL_W + 1)'(i);
      idx = idx >= NCH ? idx - NCH : idx;
      if (v_pad[idx[SEL_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_win = idx[SEL_W-1:0];
      end
    end
  end
  assign sel_ok   = {1'b0, sel} < NCH;
  assign cand     = mode ? rr_win : sel;
  assign cand_ok  = mode ? rr_hit : sel_ok;
  assign load_en  = !valid_q || out_ready;
  assign in_ready = rst_n && load_en && cand_ok ? CHANNELS'(1) << cand : '0;
  assign cap      = rst_n && load_en && cand_ok && v_pad[cand];
  always_comb begin
    valid_d = cap || (valid_q && !out_ready);
    data_d  = cap ? d_pad[cand*WIDTH +: WIDTH] : data_q;
    ch_d    = cap ? cand : ch_q;
    ptr_d   = cap && mode ? ({1'b0, rr_win} == NCH - 1'b1 ? '0 : rr_win + 1'b1) : ptr_q;
    err_d   = !mode && !sel_ok;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;
endmodule
